// File: rtl/mux_scan_nby1_pkg.sv
// Shared types and helpers for the scanning N:1 mux.
// Latency: n/a (declarations only).
// Backpressure: n/a; the mux has no flow control, outputs are sampled as produced.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  // Default dwell and the dwell counter width it implies.
  localparam int DWELL_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = $clog2(DWELL_DEFAULT + 1);

  // Dwell counter width for an arbitrary dwell setting.
  function automatic int cnt_width(input int dwell);
    return $clog2(dwell + 1);
  endfunction

  // Out-of-range manual selects collapse onto the highest channel.
  function automatic int clamp_sel(input int sel, input int n);
    return (sel >= n) ? (n - 1) : sel;
  endfunction

endpackage

// File: rtl/mux_scan_nby1_if.sv
// Bus bundle for mux_scan_nby1: source channels and controls in, sampled data out.
// Latency: n/a (wiring only).
// Backpressure: none; y_valid qualifies y/ch, the consumer must take every beat.
// y_par exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_nby1_if #(
  parameter int N = 8,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] i;
  logic [SW-1:0]  s;
  logic           mode;
  logic [N-1:0]   mask;
  logic           en;
  logic [W-1:0]   y;
  logic [SW-1:0]  ch;
  logic           y_valid;
  logic           wrap;
`ifdef MUX_SCAN_PARITY_EN
  logic           y_par;
`endif

  modport master (
    output i, s, mode, mask, en,
`ifdef MUX_SCAN_PARITY_EN
    input  y_par,
`endif
    input  y, ch, y_valid, wrap
  );

  modport slave (
    input  i, s, mode, mask, en,
`ifdef MUX_SCAN_PARITY_EN
    output y_par,
`endif
    output y, ch, y_valid, wrap
  );

endinterface

// File: rtl/mux_scan_nby1_next_ch.sv
// Cyclic priority finder: first set mask bit at/after (incl) or strictly after (excl) start.
// Latency: combinational, zero cycles.
// Backpressure: none; wrapped flags a search that passed the top index.
module mux_next_ch #(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [SW-1:0] start,
  input  logic          incl,
  output logic [SW-1:0] idx,
  output logic          found,
  output logic          wrapped
);

  // Walk N candidates from the start point, first hit wins.
  always_comb begin
    int off;
    int sum;
    int j;
    idx     = '0;
    found   = 1'b0;
    wrapped = 1'b0;
    off     = incl ? 0 : 1;
    sum     = 0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      sum = int'(start) + k + off;
      j   = (sum >= N) ? (sum - N) : sum;
      if (!found && mask[SW'(j)]) begin
        found   = 1'b1;
        idx     = SW'(j);
        wrapped = (sum >= N);
      end
    end
  end

endmodule

// File: rtl/mux_scan_nby1.sv
// N:1 mux with registered output: manual select or round-robin scan with per-channel dwell.
// Latency: one cycle from i/s/mode/en/mask to y/ch/y_valid/wrap.
// Backpressure: none; y_valid marks live samples. MUX_SCAN_PARITY_EN adds registered y_par.
module mux_scan_nby1
  import mux_scan_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = DWELL_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  mux_scan_nby1_if.slave bus
);

  localparam int SW   = $clog2(N);
  localparam int CW   = cnt_width(DWELL);
  localparam int LAST = DWELL - 1;

  state_t        state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          vld_q, vld_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          entry;
  logic          adv;
  logic [SW-1:0] nxt_idx;
  logic          nxt_found;
  logic          nxt_wrapped;

  // Scan (re)starts when coming from another state or from an empty mask.
  assign entry = (state_q != SCAN) || !vld_q;
  // Leave the current channel at end of dwell or as soon as it is masked off.
  assign adv   = (cnt_q == CW'(LAST)) || !bus.mask[ch_q];

  mux_next_ch #(.N(N)) u_next (
    .mask    (bus.mask),
    .start   (ch_q),
    .incl    (entry),
    .idx     (nxt_idx),
    .found   (nxt_found),
    .wrapped (nxt_wrapped)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Mode is re-evaluated every cycle from en/mode alone.
  always_comb begin
    state_d = IDLE;
    if (bus.en) state_d = bus.mode ? SCAN : MAN;
  end

  // Next register values for the state being entered on this edge.
  always_comb begin
    y_d    = y_q;
    ch_d   = ch_q;
    vld_d  = 1'b0;
    wrap_d = 1'b0;
    cnt_d  = '0;
    case (state_d)
      MAN: begin
        ch_d  = SW'(clamp_sel(int'(bus.s), N));
        y_d   = bus.i[int'(ch_d)*W +: W];
        vld_d = 1'b1;
      end
      SCAN: begin
        if (nxt_found) begin
          vld_d = 1'b1;
          if (entry) begin
            ch_d = nxt_idx;
          end else if (adv) begin
            ch_d   = nxt_idx;
            wrap_d = nxt_wrapped;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          y_d = bus.i[int'(ch_d)*W +: W];
        end
      end
      default: ;
    endcase
  end

  // Output and dwell registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      y_q    <= y_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.ch      = ch_q;
  assign bus.y_valid = vld_q;
  assign bus.wrap    = wrap_q;

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  // Parity tracks y, including holding with it while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^y_d;
  end

  assign bus.y_par = par_q;
`endif

endmodule
